// File: rtl/iter_mul_pkg.sv
// iter_mul_pkg: shared state encoding and default sizing for the iterative multiplier
package iter_mul_pkg;
  localparam int W_DEF = 16;
  localparam int R_DEF = 8;
  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_e;
endpackage

// File: rtl/iter_mul_datapath.sv
// mul_datapath: shift-add accumulator, operand shifters and step counter
module mul_datapath
  import iter_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           last_o,
  output logic [2*W-1:0] prod_o
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  logic [2*W-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [W-1:0]   mp_q, mp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = '0;
      mc_d  = {{W{1'b0}}, a_i};
      mp_d  = b_i;
      cnt_d = '0;
    end else if (step_i) begin
      acc_d = acc_q + (mp_q[0] ? mc_q : '0);
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
    end
  end
  assign last_o = cnt_q == CW'(W - 1);
  assign prod_o = acc_q;
endmodule

// File: rtl/iter_mul.sv
// iter_mul: W-cycle unsigned multiplier writing low/high product halves to a register file
module iter_mul
  import iter_mul_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int R = R_DEF,
  localparam int AW = (R > 1) ? $clog2(R) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic [AW-1:0] dst_i,
  input  logic          hi_en_i,
  output logic          busy_o,
  output logic          wen_o,
  output logic [AW-1:0] wa_o,
  output logic [W-1:0]  wd_o,
  output logic          done_o
);
  state_e          state_q, state_d;
  logic [AW-1:0]   dst_q, dst_d, dst_hi;
  logic            hi_q, hi_d, load, step, last;
  logic [2*W-1:0]  prod;
  mul_datapath #(.W(W)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .a_i    (a_i),
    .b_i    (b_i),
    .last_o (last),
    .prod_o (prod)
  );
  // explicit wrap so non-power-of-two register counts still land on 0
  assign dst_hi = (dst_q == AW'(R - 1)) ? '0 : dst_q + AW'(1);
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    hi_d    = hi_q;
    load    = 1'b0;
    step    = 1'b0;
    wen_o   = 1'b0;
    wa_o    = '0;
    wd_o    = '0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        load    = 1'b1;
        dst_d   = dst_i;
        hi_d    = hi_en_i;
        state_d = CALC;
      end
      CALC: begin
        step    = 1'b1;
        state_d = last ? WB_LO : CALC;
      end
      WB_LO: begin
        wen_o   = 1'b1;
        wa_o    = dst_q;
        wd_o    = prod[W-1:0];
        done_o  = !hi_q;
        state_d = hi_q ? WB_HI : IDLE;
      end
      WB_HI: begin
        wen_o   = 1'b1;
        wa_o    = dst_hi;
        wd_o    = prod[2*W-1:W];
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dst_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      hi_q    <= hi_d;
    end
  end
  assign busy_o = state_q != IDLE;
endmodule

// File: doc/iter_mul.md
ITER_MUL -- requirements
Module: iter_mul

Interface
REQ-001 Parameter W, default 16, operand and register data width.
REQ-002 Parameter R, default 8, register count; AW = clog2(R) is the register address width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 start_i  in  1  request a multiply; accepted only in IDLE.
REQ-006 a_i  in  W  multiplicand, from register-file read port 0.
REQ-007 b_i  in  W  multiplier, from register-file read port 1.
REQ-008 dst_i  in  AW  destination register for the low half of the product.
REQ-009 hi_en_i  in  1  also write the high half to register (dst_i+1) mod R.
REQ-010 busy_o  out  1  high whenever state is not IDLE.
REQ-011 wen_o  out  1  register-file write enable.
REQ-012 wa_o  out  AW  register-file write address.
REQ-013 wd_o  out  W  register-file write data.
REQ-014 done_o  out  1  one-cycle pulse coincident with the final write of an operation.

Function
REQ-015 States: IDLE, CALC, WB_LO, WB_HI.
REQ-016 IDLE, start_i=1: latch a_i, b_i, dst_i, hi_en_i; clear the 2W-bit accumulator; step counter=0; go to CALC.
REQ-017 IDLE, start_i=0: remain in IDLE; no outputs asserted.
REQ-018 CALC, each cycle: if multiplier LSB=1, add the multiplicand (zero-extended to 2W bits) to the accumulator; shift multiplicand left 1 and multiplier right 1; increment the counter.
REQ-019 CALC exits to WB_LO after exactly W cycles (counter = W-1); no early termination, including when b=0.
REQ-020 Arithmetic: unsigned; 2W-bit accumulator; no overflow possible; the low half is product[W-1:0], the high half product[2W-1:W].
REQ-021 WB_LO: wen_o=1, wa_o=latched dst, wd_o=low half; next state WB_HI if hi_en latched, else IDLE.
REQ-022 WB_HI: wen_o=1, wa_o=(latched dst+1) mod R, wd_o=high half; next state IDLE.
REQ-023 done_o=1 only in the final write state (WB_LO when hi_en=0, WB_HI when hi_en=1).
REQ-024 Latency: start accepted at cycle 0; low write at cycle W+1; high write at W+2; busy_o falls at cycle W+2 (hi_en=0) or W+3 (hi_en=1).
REQ-025 start_i while busy_o=1 is ignored; the operation in progress and its latched operands are unaffected.
REQ-026 wen_o, done_o=0 and wa_o, wd_o=0 in IDLE and CALC.
REQ-027 start_i asserted in the same cycle the FSM returns to IDLE is accepted on the following edge; back-to-back operations are separated by one IDLE cycle.
REQ-028 The dst wrap at R-1 yields high-half address 0.

Reset
REQ-029 rst_n=0 at a clock edge forces IDLE and clears the counter, accumulator and latched fields; all outputs are 0 the next cycle.
REQ-030 Reset mid-operation (CALC/WB_LO/WB_HI) aborts with no further writes; a start_i coincident with reset is discarded.

Structure
REQ-031 A shared package holds the state enum (IDLE, CALC, WB_LO, WB_HI) and default W=16, R=8 constants.
REQ-032 One sub-module, mul_datapath, holds the accumulator, shift registers and counter; iter_mul holds the FSM and output muxing.

Verification
REQ-033 a=3, b=5, dst=2, hi_en=0 -> single write wa=2, wd=15 at cycle 17; done_o at cycle 17; busy_o low at cycle 18.
REQ-034 a=16'hFFFF, b=16'hFFFF, dst=3, hi_en=1 -> wa=3 wd=16'h0001 at cycle 17, wa=4 wd=16'hFFFE at cycle 18, done_o at cycle 18 only.
REQ-035 dst=7, hi_en=1, a=16'h8000, b=4 -> writes wa=7 wd=0, then wa=0 wd=2.
REQ-036 start_i with a=9 b=9 pulsed at cycle 5 during an a=2 b=3 operation -> only wd=6 written; no second operation starts.
REQ-037 rst_n=0 at cycle 10 of an operation -> no wen_o for the rest of the test; busy_o=0 from cycle 11; a subsequent start produces correct results.
REQ-038 b=0, a=16'h1234 -> wd=0 written at cycle 17 (fixed latency confirmed).
